// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution unit.
// Latency: none (declarations and a pure helper function only).
// Backpressure: none.
package cond_pkg;

    // ARM condition field encodings
    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_t;

    // Bit positions of the NZCV flags inside the 4-bit flag word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Condition-related Decode->Execute control word. flagw is sized for the
    // widest flag-group configuration; unused upper bits stay zero.
    typedef struct packed {
        cond_t      cond;
        logic [3:0] flagw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       nowrite;
    } ectl_t;

    // A bubble is an always-executing instruction that writes nothing
    localparam ectl_t E_BUBBLE = '{
        cond:    AL,
        flagw:   4'b0000,
        pcs:     1'b0,
        regw:    1'b0,
        memw:    1'b0,
        nowrite: 1'b0
    };

    // Flag bits covered by write group g when the flag word is split into fg groups.
    // Groups that do not exist for this fg cover no bits.
    function automatic logic [3:0] group_mask(input int fg, input int g);
        logic [3:0] m;
        m = 4'b0000;
        if (g < fg) begin
            case (fg)
                1:       m = 4'b1111;
                2:       m = (g == 0) ? 4'b0011 : 4'b1100;
                default: m = 4'(4'b0001 << g);
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module cond_eval
    import cond_pkg::*;
#(
    parameter bit NV_NEVER = 1'b1
) (
    input  cond_t      i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    // Decode the condition field against the current NZCV flags
    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            EQ: o_cond_ex = w_z;
            NE: o_cond_ex = ~w_z;
            CS: o_cond_ex = w_c;
            CC: o_cond_ex = ~w_c;
            MI: o_cond_ex = w_n;
            PL: o_cond_ex = ~w_n;
            VS: o_cond_ex = w_v;
            VC: o_cond_ex = ~w_v;
            HI: o_cond_ex = w_c & ~w_z;
            LS: o_cond_ex = ~w_c | w_z;
            GE: o_cond_ex = ~(w_n ^ w_v);
            LT: o_cond_ex = w_n ^ w_v;
            GT: o_cond_ex = ~w_z & ~(w_n ^ w_v);
            LE: o_cond_ex = w_z | (w_n ^ w_v);
            AL: o_cond_ex = 1'b1;
            NV: o_cond_ex = ~NV_NEVER;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/condlogic_pipe.sv
// Pipelined conditional-execution unit: D->E control register, NZCV register, write gating.
// Latency: 1 cycle D->E; gated outputs combinational from the E register and Flags.
// Backpressure: StallE holds E and blocks the flag commit; FlushE loads a bubble and beats StallE.
module condlogic_pipe
    import cond_pkg::*;
#(
    parameter int         FG          = 2,
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter bit         NV_NEVER    = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    CondD,
    input  logic [FG-1:0] FlagWD,
    input  logic          PCSD,
    input  logic          RegWD,
    input  logic          MemWD,
    input  logic          NoWriteD,
    input  logic          StallE,
    input  logic          FlushE,
    input  logic [3:0]    ALUFlagsE,
    output logic          CondExE,
    output logic          PCSrcE,
    output logic          RegWriteE,
    output logic          MemWriteE,
    output logic [3:0]    Flags,
    output logic          carry
);

    ectl_t      r_e;
    logic [3:0] r_flags;
    ectl_t      w_e_next;
    logic       w_cond_ex;
    logic [3:0] w_grp_wr;
    logic [3:0] w_bit_we;

    // Pack the Decode controls into the E-stage word
    always_comb begin
        w_e_next         = E_BUBBLE;
        w_e_next.cond    = cond_t'(CondD);
        w_e_next.flagw   = 4'(FlagWD);
        w_e_next.pcs     = PCSD;
        w_e_next.regw    = RegWD;
        w_e_next.memw    = MemWD;
        w_e_next.nowrite = NoWriteD;
    end

    // E register: flush beats stall, stall holds, otherwise capture Decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e <= E_BUBBLE;
        end else if (FlushE) begin
            r_e <= E_BUBBLE;
        end else if (!StallE) begin
            r_e <= w_e_next;
        end
    end

    cond_eval #(
        .NV_NEVER (NV_NEVER)
    ) u_cond_eval (
        .i_cond    (r_e.cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    // Group write strobes: only a passing, unstalled instruction commits flags
    assign w_grp_wr = r_e.flagw & {4{w_cond_ex & ~StallE}};

    // Expand group strobes into per-bit enables for the configured grouping
    always_comb begin
        w_bit_we = 4'b0000;
        for (int g = 0; g < 4; g++) begin
            if (w_grp_wr[g]) begin
                w_bit_we = w_bit_we | group_mask(FG, g);
            end
        end
    end

    // Flag register: enabled bits take the ALU result, the rest hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= RESET_FLAGS;
        end else begin
            r_flags <= (r_flags & ~w_bit_we) | (ALUFlagsE & w_bit_we);
        end
    end

    assign CondExE   = w_cond_ex;
    assign PCSrcE    = r_e.pcs & w_cond_ex;
    assign RegWriteE = r_e.regw & w_cond_ex & ~r_e.nowrite;
    assign MemWriteE = r_e.memw & w_cond_ex;
    assign Flags     = r_flags;
    assign carry     = r_flags[FLAG_C];

endmodule
